nrdiv_seq: RTL and testbench

NRDIV_SEQ -- requirements
Module: nrdiv_seq

---
 rtl/nrdiv_pkg.sv | 14 +
 rtl/nrdiv_addsub.sv | 16 +
 rtl/nrdiv_seq.sv | 148 ++++++++++++++
 tb/tb_nrdiv_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nrdiv_pkg.sv
// Shared definitions for the sequential non-restoring divider:
// the default operand width and the controller state encoding.
package nrdiv_pkg;

  localparam int NRDIV_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_CORR = 2'd2,
    ST_FIN  = 2'd3
  } nrdiv_state_e;

endpackage

// File: rtl/nrdiv_addsub.sv
// Signed WIDTH+1-bit adder/subtractor used for every partial-remainder
// update, both in the iteration steps and in the final correction.
module nrdiv_addsub
  import nrdiv_pkg::*;
#(
  parameter int WIDTH = NRDIV_WIDTH_DEF
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] y_o
);

  assign y_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/nrdiv_seq.sv
// Sequential unsigned non-restoring divider: one quotient bit per cycle,
// a single remainder-correction cycle, then a one-cycle Done pulse.
module nrdiv_seq
  import nrdiv_pkg::*;
#(
  parameter int WIDTH = NRDIV_WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R
);

  localparam int CW = $clog2(WIDTH) + 1;

  nrdiv_state_e     state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   as_a;
  logic [WIDTH:0]   as_b;
  logic [WIDTH:0]   as_y;
  logic             as_sub;

  assign p_sh = {p_q[WIDTH-1:0], a_q[WIDTH-1]};

  // The shared adder sees the shifted remainder while iterating and the
  // unshifted one during correction, where it only ever adds D back.
  always_comb begin
    as_b   = {1'b0, d_q};
    as_a   = p_q;
    as_sub = 1'b0;
    if (state_q == ST_ITER) begin
      as_a   = p_sh;
      as_sub = ~p_q[WIDTH];
    end
  end

  nrdiv_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a_i  (as_a),
    .b_i  (as_b),
    .sub_i(as_sub),
    .y_o  (as_y)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (Divisor == '0) begin
            q_d     = '1;
            r_d     = Dividend;
            dz_d    = 1'b1;
            state_d = ST_FIN;
          end else begin
            p_d     = '0;
            a_d     = Dividend;
            d_d     = Divisor;
            cnt_d   = '0;
            state_d = ST_ITER;
          end
        end
      end

      ST_ITER: begin
        p_d   = as_y;
        a_d   = {a_q[WIDTH-2:0], ~as_y[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_CORR;
        end
      end

      // Results are published only here, so partial values never reach Q/R.
      ST_CORR: begin
        if (p_q[WIDTH]) begin
          p_d = as_y;
          r_d = as_y[WIDTH-1:0];
        end else begin
          r_d = p_q[WIDTH-1:0];
        end
        q_d     = a_q;
        dz_d    = 1'b0;
        state_d = ST_FIN;
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      a_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign Busy    = (state_q == ST_ITER) || (state_q == ST_CORR);
  assign Done    = (state_q == ST_FIN);
  assign DivZero = dz_q;
  assign Q       = q_q;
  assign R       = r_q;

endmodule

// File: tb/tb_nrdiv_seq.sv
// Directed and randomised checks of nrdiv_seq at WIDTH 8 and 16.
module tb_nrdiv_seq;

  logic        Clk = 1'b0;
  logic        Reset_n;

  logic        start8;
  logic [7:0]  x8, d8;
  logic        busy8, done8, dz8;
  logic [7:0]  q8, r8;

  logic        start16;
  logic [15:0] x16, d16;
  logic        busy16, done16, dz16;
  logic [15:0] q16, r16;

  int checkCount = 0;
  int failCount  = 0;

  int lat, busyCnt, doneCnt;
  logic pulseLow;
  int xr, dr, eq, er, ez;

  logic [7:0] vx [6] = '{8'd80, 8'd200, 8'd5, 8'd255, 8'd255, 8'd77};
  logic [7:0] vd [6] = '{8'd20, 8'd7,   8'd9, 8'd1,   8'd255, 8'd0};
  logic [7:0] vq [6] = '{8'd4,  8'd28,  8'd0, 8'd255, 8'd1,   8'hFF};
  logic [7:0] vr [6] = '{8'd0,  8'd4,   8'd5, 8'd0,   8'd0,   8'd77};
  logic       vz [6] = '{1'b0,  1'b0,   1'b0, 1'b0,   1'b0,   1'b1};
  int         vl [6] = '{10,    10,     10,   10,     10,     1};
  int         vb [6] = '{9,     9,      9,    9,      9,      0};

  nrdiv_seq #(.WIDTH(8)) dut8 (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (start8),
    .Dividend(x8),
    .Divisor (d8),
    .Busy    (busy8),
    .Done    (done8),
    .DivZero (dz8),
    .Q       (q8),
    .R       (r8)
  );

  nrdiv_seq #(.WIDTH(16)) dut16 (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (start16),
    .Dividend(x16),
    .Divisor (d16),
    .Busy    (busy16),
    .Done    (done16),
    .DivZero (dz16),
    .Q       (q16),
    .R       (r16)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launches one 8-bit division and returns its latency in cycles counted
  // from the accepting edge, how many cycles Busy was high, and whether Done
  // dropped again one cycle after its pulse.
  task automatic applyStimulus8(input logic [7:0] x, input logic [7:0] d,
                                output int latOut, output int busyOut, output logic lowOut);
    x8 = x;
    d8 = d;
    start8 = 1'b1;
    latOut = 0;
    busyOut = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      start8 = 1'b0;
      latOut++;
      if (busy8) busyOut++;
      if (done8) break;
    end
    @(posedge Clk);
    #1;
    lowOut = ~done8;
  endtask

  task automatic applyStimulus16(input logic [15:0] x, input logic [15:0] d, output int latOut);
    x16 = x;
    d16 = d;
    start16 = 1'b1;
    latOut = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge Clk);
      #1;
      start16 = 1'b0;
      latOut++;
      if (done16) break;
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0;
    start8 = 1'b0;  x8 = '0;  d8 = '0;
    start16 = 1'b0; x16 = '0; d16 = '0;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_done", 32'(done8), 32'd0);
    checkOutput("rst_q", 32'(q8), 32'd0);
    checkOutput("rst_r", 32'(r8), 32'd0);
    checkOutput("rst_dz", 32'(dz8), 32'd0);
    Reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus8(vx[i], vd[i], lat, busyCnt, pulseLow);
      checkOutput($sformatf("v%0d_lat", i), 32'(lat), 32'(vl[i]));
      checkOutput($sformatf("v%0d_busy", i), 32'(busyCnt), 32'(vb[i]));
      checkOutput($sformatf("v%0d_pulse", i), 32'(pulseLow), 32'd1);
      checkOutput($sformatf("v%0d_q", i), 32'(q8), 32'(vq[i]));
      checkOutput($sformatf("v%0d_r", i), 32'(r8), 32'(vr[i]));
      checkOutput($sformatf("v%0d_dz", i), 32'(dz8), 32'(vz[i]));
    end

    // Starts during ITER and FIN, plus operand changes, must not disturb 80/20.
    x8 = 8'd80; d8 = 8'd20; start8 = 1'b1;
    lat = 1; doneCnt = 0;
    @(posedge Clk); #1;
    start8 = 1'b0; x8 = 8'd10; d8 = 8'd3;
    repeat (2) @(posedge Clk);
    #1;
    lat += 2;
    start8 = 1'b1;
    @(posedge Clk); #1;
    start8 = 1'b0;
    lat++;
    for (int i = 0; i < 30 && !done8; i++) begin
      @(posedge Clk); #1;
      lat++;
    end
    if (done8) doneCnt++;
    checkOutput("ign_lat", 32'(lat), 32'd10);
    start8 = 1'b1; x8 = 8'd9; d8 = 8'd0;
    @(posedge Clk); #1;
    start8 = 1'b0;
    checkOutput("ign_fin_done", 32'(done8), 32'd0);
    checkOutput("ign_fin_busy", 32'(busy8), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      if (done8) doneCnt++;
    end
    checkOutput("ign_done_cnt", 32'(doneCnt), 32'd1);
    checkOutput("ign_q", 32'(q8), 32'd4);
    checkOutput("ign_r", 32'(r8), 32'd0);
    checkOutput("ign_dz", 32'(dz8), 32'd0);

    applyStimulus8(8'd200, 8'd7, lat, busyCnt, pulseLow);
    checkOutput("pre_rst_q", 32'(q8), 32'd28);

    // Abort mid-iteration, then start in the very first cycle after release.
    x8 = 8'd80; d8 = 8'd20; start8 = 1'b1;
    @(posedge Clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    checkOutput("abort_busy", 32'(busy8), 32'd0);
    checkOutput("abort_done", 32'(done8), 32'd0);
    checkOutput("abort_q", 32'(q8), 32'd0);
    checkOutput("abort_r", 32'(r8), 32'd0);
    checkOutput("abort_dz", 32'(dz8), 32'd0);
    Reset_n = 1'b1;
    applyStimulus8(8'd100, 8'd3, lat, busyCnt, pulseLow);
    checkOutput("post_rst_lat", 32'(lat), 32'd10);
    checkOutput("post_rst_q", 32'(q8), 32'd33);
    checkOutput("post_rst_r", 32'(r8), 32'd1);

    Reset_n = 1'b0; start8 = 1'b1; x8 = 8'd77; d8 = 8'd0;
    @(posedge Clk); #1;
    checkOutput("prio_done", 32'(done8), 32'd0);
    checkOutput("prio_dz", 32'(dz8), 32'd0);
    start8 = 1'b0;
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < 1000; i++) begin
      xr = int'($urandom_range(0, 65535));
      dr = int'($urandom_range(1, 65535));
      if (i % 10 == 0) dr = 0;
      if (i % 10 == 1) xr = 0;
      if (i % 10 == 2) begin
        xr = int'($urandom_range(0, 60000));
        dr = xr + 1 + int'($urandom_range(0, 65534 - xr));
      end
      if (dr == 0) begin
        eq = 65535; er = xr; ez = 1;
      end else begin
        eq = xr / dr; er = xr % dr; ez = 0;
      end
      applyStimulus16(16'(xr), 16'(dr), lat);
      checkOutput($sformatf("w16_%0d_lat", i), 32'(lat), (dr == 0) ? 32'd1 : 32'd18);
      checkOutput($sformatf("w16_%0d_q", i), 32'(q16), 32'(eq));
      checkOutput($sformatf("w16_%0d_r", i), 32'(r16), 32'(er));
      checkOutput($sformatf("w16_%0d_dz", i), 32'(dz16), 32'(ez));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
